// File: rtl/pe1x1_mac.sv
// 1x1 convolution PE: LANES signed Q(IW.FW) multipliers sharing one weight, accumulating
// a channel stream, then bias, saturation and optional ReLU per output pixel group.
module pe1x1_mac #(
    parameter int unsigned LANES = 7,
    parameter int unsigned IW    = 24,
    parameter int unsigned FW    = 8,
    parameter int unsigned GUARD = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        in_last_i,
    input  logic [LANES*(IW+FW)-1:0]    fmap_i,
    input  logic [IW+FW-1:0]            wht_i,
    input  logic [IW+FW-1:0]            bias_i,
    input  logic                        relu_en_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*(IW+FW)-1:0]    res_o,
    output logic [LANES-1:0]            sat_o
);

    localparam int unsigned DW   = IW + FW;
    localparam int unsigned ACCW = DW + GUARD;
    localparam int unsigned PW   = 2 * DW;
    // Two extra bits so acc + p + bias can never wrap before the clamp.
    localparam int unsigned SW   = ACCW + 2;

    localparam logic [SW-1:0] MaxS = {{(SW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic [SW-1:0] MinS = {{(SW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {StAcc, StFlush, StOut} state_e;

    state_e                        state_q, state_d;
    logic [LANES-1:0][ACCW-1:0]    acc_q, acc_d;
    logic [LANES-1:0][ACCW-1:0]    p_q, p_d;
    logic                          pv_q, pv_d;
    logic [DW-1:0]                 bias_q, bias_d;
    logic                          relu_q, relu_d;
    logic [LANES*DW-1:0]           res_q, res_d;
    logic [LANES-1:0]              sat_q, sat_d;
    logic                          ov_q, ov_d;

    logic [LANES-1:0][PW-1:0]      prod;
    logic [LANES-1:0][ACCW-1:0]    lane_p;
    logic [LANES-1:0][SW-1:0]      sum;
    logic [LANES-1:0][DW-1:0]      r;
    logic [LANES-1:0]              r_sat;
    logic                          accept;

    assign in_ready_o  = rst_n && (state_q == StAcc);
    assign accept      = in_valid_i && (state_q == StAcc);
    assign out_valid_o = ov_q;
    assign res_o       = res_q;
    assign sat_o       = sat_q;

    // Per-lane datapath: floor-shifted product, final sum, clamp and ReLU.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod[k]   = PW'($signed(fmap_i[k*DW +: DW])) * PW'($signed(wht_i));
            lane_p[k] = ACCW'($signed(prod[k]) >>> FW);
            sum[k]    = SW'($signed(acc_q[k])) + SW'($signed(p_q[k])) + SW'($signed(bias_q));
            r_sat[k]  = 1'b0;
            if ($signed(sum[k]) > $signed(MaxS)) begin
                r[k]     = MaxS[DW-1:0];
                r_sat[k] = 1'b1;
            end else if ($signed(sum[k]) < $signed(MinS)) begin
                r[k]     = MinS[DW-1:0];
                r_sat[k] = 1'b1;
            end else begin
                r[k] = sum[k][DW-1:0];
            end
            if (relu_q && r[k][DW-1]) begin
                r[k] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        p_d     = p_q;
        pv_d    = accept;
        bias_d  = bias_q;
        relu_d  = relu_q;
        res_d   = res_q;
        sat_d   = sat_q;
        ov_d    = ov_q;
        unique case (state_q)
            StAcc: begin
                if (pv_q) begin
                    for (int k = 0; k < LANES; k++) begin
                        acc_d[k] = acc_q[k] + p_q[k];
                    end
                end
                if (accept) begin
                    p_d = lane_p;
                    if (in_last_i) begin
                        bias_d  = bias_i;
                        relu_d  = relu_en_i;
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                res_d   = r;
                sat_d   = r_sat;
                ov_d    = 1'b1;
                acc_d   = '0;
                state_d = StOut;
            end
            StOut: begin
                if (out_ready_i) begin
                    ov_d    = 1'b0;
                    sat_d   = '0;
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= '0;
            p_q     <= '0;
            pv_q    <= 1'b0;
            bias_q  <= '0;
            relu_q  <= 1'b0;
            res_q   <= '0;
            sat_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            pv_q    <= pv_d;
            bias_q  <= bias_d;
            relu_q  <= relu_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_pe1x1_mac.sv
// Bench for pe1x1_mac: arithmetic reference model checked every cycle, directed literal
// cases for the numeric corner cases, then randomized groups with random backpressure.
module tb_pe1x1_mac;

    localparam int LANES = 7;
    localparam int DW    = 32;
    localparam int CW    = LANES * DW;
    typedef logic [CW-1:0] cv_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             in_last_i = 1'b0;
    logic             relu_en_i = 1'b0;
    logic             out_ready_i = 1'b0;
    cv_t              fmap_i = '0;
    logic [DW-1:0]    wht_i = '0;
    logic [DW-1:0]    bias_i = '0;
    logic             in_ready_o;
    logic             out_valid_o;
    cv_t              res_o;
    logic [LANES-1:0] sat_o;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    pe1x1_mac #(.LANES(LANES), .IW(24), .FW(8), .GUARD(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_last_i   (in_last_i),
        .fmap_i      (fmap_i),
        .wht_i       (wht_i),
        .bias_i      (bias_i),
        .relu_en_i   (relu_en_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o),
        .sat_o       (sat_o)
    );

    task automatic check(input string name, input cv_t got, input cv_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Reference model: Q24.8 arithmetic on 64-bit integers, accumulator wrapped to 40 bits.
    function automatic longint wrap40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    function automatic longint lanep(input logic [DW-1:0] f, input logic [DW-1:0] w);
        longint pf;
        pf = longint'($signed(f)) * longint'($signed(w));
        return wrap40(pf >>> 8);
    endfunction

    function automatic cv_t fill(input logic [DW-1:0] v);
        cv_t f;
        for (int k = 0; k < LANES; k++) f[k*DW +: DW] = v;
        return f;
    endfunction

    longint           acc_m [LANES];
    int               phase = 0;
    bit               m_acc = 1'b0;
    bit               exp_valid = 1'b0;
    cv_t              exp_res = '0;
    cv_t              pend_res = '0;
    logic [LANES-1:0] exp_sat = '0;
    logic [LANES-1:0] pend_sat = '0;

    initial begin
        longint p, s, r;
        foreach (acc_m[k]) acc_m[k] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            m_acc = 1'b0;
            if (!rst_n) begin
                phase = 0;
                exp_valid = 1'b0;
                exp_res = '0;
                exp_sat = '0;
                foreach (acc_m[k]) acc_m[k] = 0;
            end else begin
                case (phase)
                    0: if (in_valid_i) begin
                        m_acc = 1'b1;
                        for (int k = 0; k < LANES; k++) begin
                            p = lanep(fmap_i[k*DW +: DW], wht_i);
                            if (!in_last_i) begin
                                acc_m[k] = wrap40(acc_m[k] + p);
                            end else begin
                                s = acc_m[k] + p + longint'($signed(bias_i));
                                pend_sat[k] = 1'b0;
                                if (s > 64'sd2147483647) begin
                                    r = 64'sd2147483647;
                                    pend_sat[k] = 1'b1;
                                end else if (s < -64'sd2147483648) begin
                                    r = -64'sd2147483648;
                                    pend_sat[k] = 1'b1;
                                end else begin
                                    r = s;
                                end
                                if (relu_en_i && r < 0) r = 0;
                                pend_res[k*DW +: DW] = r[DW-1:0];
                                acc_m[k] = 0;
                            end
                        end
                        if (in_last_i) phase = 1;
                    end
                    1: begin
                        exp_res = pend_res;
                        exp_sat = pend_sat;
                        exp_valid = 1'b1;
                        phase = 2;
                    end
                    default: if (out_ready_i) begin
                        exp_valid = 1'b0;
                        exp_sat = '0;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("in_ready", cv_t'(in_ready_o), cv_t'(rst_n && phase == 0));
        check("out_valid", cv_t'(out_valid_o), cv_t'(exp_valid));
        check("sat", cv_t'(sat_o), cv_t'(exp_sat));
        check("res", res_o, exp_res);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic drive_beat(input cv_t fm, input logic [DW-1:0] w, input bit last,
                              input logic [DW-1:0] b, input bit relu);
        int n = 0;
        fmap_i = fm;
        wht_i = w;
        in_last_i = last;
        bias_i = b;
        relu_en_i = relu;
        in_valid_i = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 200);
        in_valid_i = 1'b0;
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: not accepted within %0d cycles, required acceptance", n);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid_o) return;
        end
        checks++;
        errors++;
        $display("FAIL out_valid_timeout: out_valid_o still 0 after 20 cycles, required 1");
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lanes(input string name, input logic [DW-1:0] v);
        for (int k = 0; k < LANES; k++) check(name, cv_t'(res_o[k*DW +: DW]), cv_t'(v));
    endtask

    initial begin
        cv_t fm;
        logic [DW-1:0] w, t;
        int nb;
        bit big, relu;

        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_ready", cv_t'(in_ready_o), cv_t'(1'b0));
        check("reset_valid", cv_t'(out_valid_o), cv_t'(1'b0));
        check("reset_res", res_o, '0);
        sync();
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cv_t'(in_ready_o), cv_t'(1'b1));
        sync();
        out_ready_i = 1'b1;

        // 3 beats of 2.0*1.5 plus 0.5 bias = 9.5
        drive_beat(fill(32'd512), 32'd384, 1'b0, 32'd128, 1'b0);
        drive_beat(fill(32'd512), 32'd384, 1'b0, 32'd128, 1'b0);
        drive_beat(fill(32'd512), 32'd384, 1'b1, 32'd128, 1'b0);
        wait_valid();
        check_lanes("basic_res", 32'd2432);
        check("basic_sat", cv_t'(sat_o), '0);
        sync();

        fm = '0;
        fm[DW-1:0] = 32'hFFFF_FFFF;
        fm[2*DW-1:DW] = 32'd1;
        drive_beat(fm, 32'd128, 1'b1, 32'd0, 1'b0);
        wait_valid();
        check("trunc_lane0", cv_t'(res_o[DW-1:0]), cv_t'(32'hFFFF_FFFF));
        check("trunc_lane1", cv_t'(res_o[2*DW-1:DW]), '0);
        sync();

        drive_beat(fill(32'h7FFF_FFFF), 32'd512, 1'b0, 32'd0, 1'b0);
        drive_beat(fill(32'h7FFF_FFFF), 32'd512, 1'b1, 32'd0, 1'b0);
        wait_valid();
        check_lanes("sat_res", 32'h7FFF_FFFF);
        check("sat_flags", cv_t'(sat_o), cv_t'(7'h7F));
        sync();

        drive_beat(fill(32'hFFFF_FE00), 32'd256, 1'b1, 32'd0, 1'b1);
        wait_valid();
        check_lanes("relu_on_res", 32'd0);
        check("relu_on_sat", cv_t'(sat_o), '0);
        sync();
        drive_beat(fill(32'hFFFF_FE00), 32'd256, 1'b1, 32'd0, 1'b0);
        wait_valid();
        check_lanes("relu_off_res", 32'hFFFF_FE00);
        sync();

        // Backpressure: junk beats offered while the result is stalled must be ignored.
        out_ready_i = 1'b0;
        drive_beat(fill(32'd300), 32'd700, 1'b1, 32'd5, 1'b0);
        wait_valid();
        sync();
        for (int i = 0; i < 5; i++) begin
            fmap_i = fill(32'd999);
            wht_i = 32'd999;
            in_last_i = 1'b1;
            in_valid_i = 1'b1;
            sync();
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        sync();
        drive_beat(fill(32'd256), 32'd256, 1'b1, 32'd0, 1'b0);
        wait_valid();
        check_lanes("after_bp_res", 32'd256);
        sync();

        drive_beat(fill(32'd768), 32'd256, 1'b1, 32'd0, 1'b0);
        drive_beat(fill(32'hFFFF_FF00), 32'd512, 1'b1, 32'd100, 1'b0);
        wait_valid();
        check_lanes("b2b_second", 32'hFFFF_FE64);
        sync();

        drive_beat(fill(32'd1000), 32'd1000, 1'b0, 32'd0, 1'b0);
        drive_beat(fill(32'd1000), 32'd1000, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_res", res_o, '0);
        check("midrst_valid", cv_t'(out_valid_o), '0);
        sync();
        rst_n = 1'b1;
        drive_beat(fill(32'd256), 32'd256, 1'b1, 32'd0, 1'b0);
        wait_valid();
        check_lanes("midrst_new", 32'd256);
        sync();

        rand_rdy = 1'b1;
        for (int g = 0; g < 40; g++) begin
            nb = $urandom_range(1, 5);
            big = ($urandom_range(0, 3) == 0);
            relu = $urandom_range(0, 1) == 1;
            t = $urandom_range(0, 65535);
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < LANES; k++) begin
                    w = $urandom_range(0, 65535);
                    fm[k*DW +: DW] = big ? $urandom : w - 32'd32768;
                end
                w = $urandom_range(0, 4095);
                w = big ? $urandom : w - 32'd2048;
                if ($urandom_range(0, 3) == 0) sync();
                drive_beat(fm, w, b == nb - 1, t - 32'd32768, relu);
            end
        end
        rand_rdy = 1'b0;
        sync();
        out_ready_i = 1'b1;
        repeat (10) sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
